// File: rtl/ids_chi_monitor.sv
// Streaming intrusion-detection monitor: windowed symbol histogram, scaled chi-squared
// against a uniform expectation, and a hysteretic alarm driven by hot/cool window streaks.
module ids_chi_monitor #(
  parameter int DATA_WIDTH  = 8,
  parameter int BIN_BITS    = 4,
  parameter int WINSIZE     = 256,
  parameter int CHI_WIDTH   = 32,
  parameter int TRIP_COUNT  = 2,
  parameter int CLEAR_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CHI_WIDTH-1:0]  thr_hi,
  input  logic [CHI_WIDTH-1:0]  thr_lo,
  output logic [CHI_WIDTH-1:0]  chi_out,
  output logic                  chi_vld,
  output logic                  alarm,
  output logic [15:0]           win_cnt
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam int E     = WINSIZE / NBINS;
  localparam int CW    = $clog2(WINSIZE + 1);
  localparam int SW    = $clog2(WINSIZE);
  localparam int QW    = 2 * CW;
  localparam int AW    = ((CHI_WIDTH > QW) ? CHI_WIDTH : QW) + 1;
  localparam int HW    = $clog2(TRIP_COUNT + 1);
  localparam int LW    = $clog2(CLEAR_COUNT + 1);

  localparam logic [CW-1:0]        E_C     = CW'(E);
  localparam logic [CHI_WIDTH-1:0] ACC_MAX = {CHI_WIDTH{1'b1}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          bank [2][NBINS];
  logic                   fill_sel;
  logic                   scan_sel;
  logic [SW-1:0]          s;
  logic [BIN_BITS-1:0]    idx;
  logic [BIN_BITS-1:0]    bin;
  logic [CHI_WIDTH-1:0]   acc, acc_nx;
  logic [CW-1:0]          obs, dev;
  logic [AW-1:0]          dev_w, sum;
  logic [HW-1:0]          hot_n, hot_nx;
  logic [LW-1:0]          cool_n, cool_nx;
  logic                   alarm_nx;
  logic                   win_done, last, hot, cool;
  logic                   unused_data;

  assign bin         = data_in[DATA_WIDTH-1 -: BIN_BITS];
  assign unused_data = ^data_in;
  assign scan_sel    = ~fill_sel;
  assign win_done    = in_valid && (s == SW'(WINSIZE - 1));
  assign last        = (state == SCAN) && (idx == '1);

  always_comb begin
    state_nx = state;
    hot_nx   = hot_n;
    cool_nx  = cool_n;
    alarm_nx = alarm;
    obs      = bank[scan_sel][idx];
    dev      = (obs >= E_C) ? (obs - E_C) : (E_C - obs);
    dev_w    = AW'(dev);
    sum      = AW'(acc) + dev_w * dev_w;
    acc_nx   = (sum > AW'(ACC_MAX)) ? ACC_MAX : sum[CHI_WIDTH-1:0];
    hot      = (acc_nx >= thr_hi);
    cool     = !hot && (acc_nx < thr_lo);

    case (state)
      IDLE:    if (win_done) state_nx = SCAN;
      SCAN:    if (last)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // The streak that reaches its limit on this very window flips the alarm.
    if (last) begin
      if (hot) begin
        cool_nx = '0;
        hot_nx  = (hot_n == HW'(TRIP_COUNT)) ? hot_n : hot_n + HW'(1);
        if (hot_nx == HW'(TRIP_COUNT)) alarm_nx = 1'b1;
      end else if (cool) begin
        hot_nx  = '0;
        cool_nx = (cool_n == LW'(CLEAR_COUNT)) ? cool_n : cool_n + LW'(1);
        if (cool_nx == LW'(CLEAR_COUNT)) alarm_nx = 1'b0;
      end else begin
        hot_nx  = '0;
        cool_nx = '0;
      end
    end
  end

  // Fill and scan always target different banks, so both writes can land in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBINS; b++) begin
        bank[0][b] <= '0;
        bank[1][b] <= '0;
      end
      state    <= IDLE;
      fill_sel <= 1'b0;
      s        <= '0;
      idx      <= '0;
      acc      <= '0;
      hot_n    <= '0;
      cool_n   <= '0;
      chi_out  <= '0;
      chi_vld  <= 1'b0;
      alarm    <= 1'b0;
      win_cnt  <= '0;
    end else begin
      state   <= state_nx;
      chi_vld <= last;
      hot_n   <= hot_nx;
      cool_n  <= cool_nx;
      alarm   <= alarm_nx;

      if (in_valid) begin
        bank[fill_sel][bin] <= bank[fill_sel][bin] + CW'(1);
        s <= win_done ? '0 : s + SW'(1);
        if (win_done) fill_sel <= ~fill_sel;
      end

      if (state == SCAN) begin
        bank[scan_sel][idx] <= '0;
        acc <= acc_nx;
        idx <= idx + BIN_BITS'(1);
      end else begin
        acc <= '0;
        idx <= '0;
      end

      if (last) begin
        chi_out <= acc_nx;
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ids_chi_monitor.sv
// Directed bench for ids_chi_monitor: a default instance plus a narrow-statistic instance
// sharing the same stimulus, with windows recorded at each chi_vld and compared to constants.
module tb_ids_chi_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  data_in;
  logic [31:0] thr_hi, thr_lo;

  logic [31:0] chi_out;
  logic        chi_vld, alarm;
  logic [15:0] win_cnt;

  logic [14:0] chi_out2;
  logic        chi_vld2, alarm2;
  logic [15:0] win_cnt2;

  int checks = 0;
  int errors = 0;
  int ec = 0;

  int          q_ec[$];
  logic [31:0] q_chi[$];
  logic        q_alarm[$];
  logic [15:0] q_win[$];
  logic [14:0] q_chi2[$];
  logic        q_alarm2[$];

  int counts[16];
  int st[11];

  int exp_chi[11]   = '{0, 61440, 61440, 700, 0, 0, 61440, 700, 61440, 61440, 0};
  int exp_chi2[11]  = '{0, 32767, 32767, 700, 0, 0, 32767, 700, 32767, 32767, 0};
  int exp_alarm[11] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
  int exp_win[11]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 1};

  ids_chi_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .chi_out(chi_out), .chi_vld(chi_vld), .alarm(alarm), .win_cnt(win_cnt)
  );

  // 15-bit statistic so a single-bin window overflows on its first bin.
  ids_chi_monitor #(.CHI_WIDTH(15)) dut_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .thr_hi(thr_hi[14:0]), .thr_lo(thr_lo[14:0]),
    .chi_out(chi_out2), .chi_vld(chi_vld2), .alarm(alarm2), .win_cnt(win_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ec <= ec + 1;

  always @(negedge clk) begin
    if (chi_vld) begin
      q_ec.push_back(ec);
      q_chi.push_back(chi_out);
      q_alarm.push_back(alarm);
      q_win.push_back(win_cnt);
    end
    if (chi_vld2) begin
      q_chi2.push_back(chi_out2);
      q_alarm2.push_back(alarm2);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic put_sample(input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    data_in  = d;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_counts(input int mode);
    for (int b = 0; b < 16; b++) counts[b] = (mode == 0 || mode == 2) ? 16 : 0;
    if (mode == 1) counts[0] = 256;
    if (mode == 2) begin
      counts[0] = 36; counts[1] = 6;  counts[2] = 6;  counts[3] = 21;
      counts[4] = 11; counts[5] = 21; counts[6] = 11;
    end
  endtask

  // mode 0 uniform, 1 all in bin 0, 2 neutral (statistic 700); gap_every>0 inserts stalls
  task automatic send_window(input int mode, input int gap_every, output int first_ec);
    int n;
    n = 0;
    first_ec = 0;
    set_counts(mode);
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < counts[b]; k++) begin
        if (gap_every > 0 && n > 0 && (n % gap_every) == 0) idle_cycle();
        put_sample({4'(b), 4'(n)});
        if (n == 0) first_ec = ec;
        n++;
      end
    end
  endtask

  task automatic wait_vld(input int n);
    int k;
    k = 0;
    while (q_chi.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("vld_count", 64'(q_chi.size()), 64'(n));
  endtask

  task automatic check_window(input int i);
    if (i < q_chi.size() && i < q_chi2.size()) begin
      check($sformatf("chi_w%0d", i), 64'(q_chi[i]), 64'(exp_chi[i]));
      check($sformatf("alarm_w%0d", i), 64'(q_alarm[i]), 64'(exp_alarm[i]));
      check($sformatf("win_cnt_w%0d", i), 64'(q_win[i]), 64'(exp_win[i]));
      check($sformatf("chi_narrow_w%0d", i), 64'(q_chi2[i]), 64'(exp_chi2[i]));
      check($sformatf("alarm_narrow_w%0d", i), 64'(q_alarm2[i]), 64'(exp_alarm[i]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    thr_hi   = 32'd1000;
    thr_lo   = 32'd500;

    repeat (3) @(posedge clk);
    #1;
    check("reset_chi_out", 64'(chi_out), 64'd0);
    check("reset_chi_vld", 64'(chi_vld), 64'd0);
    check("reset_alarm", 64'(alarm), 64'd0);
    check("reset_win_cnt", 64'(win_cnt), 64'd0);
    check("reset_chi_narrow", 64'(chi_out2), 64'd0);
    rst = 1'b0;

    // Six windows back to back at one sample per cycle.
    send_window(0, 0, st[0]);
    send_window(1, 0, st[1]);
    send_window(1, 0, st[2]);
    send_window(2, 0, st[3]);
    send_window(0, 0, st[4]);
    send_window(0, 0, st[5]);
    idle_cycle();
    wait_vld(6);
    repeat (30) @(negedge clk);
    check("vld_pulse_count", 64'(q_chi.size()), 64'd6);
    check("vld_narrow_count", 64'(q_chi2.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check_window(i);
      if (i < q_ec.size()) check($sformatf("latency_w%0d", i), 64'(q_ec[i] - st[i]), 64'd272);
    end
    if (q_ec.size() >= 2) check("vld_spacing", 64'(q_ec[1] - q_ec[0]), 64'd256);

    // Hot, neutral, hot with stalls: neutral resets the streak; a further hot trips.
    send_window(1, 37, st[6]);
    send_window(2, 37, st[7]);
    send_window(1, 37, st[8]);
    send_window(1, 0, st[9]);
    idle_cycle();
    wait_vld(10);
    for (int i = 6; i < 10; i++) check_window(i);

    // Reset in the middle of a window while alarm is high.
    for (int n = 0; n < 100; n++) put_sample({4'(n % 16), 4'(n)});
    check("pre_reset_alarm", 64'(alarm), 64'd1);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_chi_out", 64'(chi_out), 64'd0);
    check("async_rst_alarm", 64'(alarm), 64'd0);
    check("async_rst_win_cnt", 64'(win_cnt), 64'd0);
    check("async_rst_chi_vld", 64'(chi_vld), 64'd0);
    check("async_rst_narrow_alarm", 64'(alarm2), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("no_vld_during_reset", 64'(q_chi.size()), 64'd10);

    send_window(0, 0, st[10]);
    idle_cycle();
    wait_vld(11);
    check_window(10);
    if (q_ec.size() > 10) check("latency_after_reset", 64'(q_ec[10] - st[10]), 64'd272);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
